// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bundle for the byte-addressed load/store unit.
// slave: the LSU view; master: the pipeline plus data-memory side.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [17:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        done;
   logic [31:0] load_data;
   logic        misaligned;
   logic [15:0] memory_address;
   logic [31:0] write_data;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] read_data;

   modport slave (
      input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, read_data,
      output req_ready, done, load_data, misaligned, memory_address, write_data,
             mem_write, mem_read
   );

   modport master (
      output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, read_data,
      input  req_ready, done, load_data, misaligned, memory_address, write_data,
             mem_write, mem_read
   );
endinterface

// File: rtl/load_store_unit.sv
// Big-endian byte/half/word load-store front end with read-modify-write for sub-word stores.
// Optional alignment rejection is enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit (
   input  logic             clock,
   input  logic             reset,
   load_store_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LD, ST_RD, ST_WR} state_t;

   state_t      state;
   logic [17:0] addr_p0;
   logic [1:0]  size_p0;
   logic        sgn_p0;
   logic [31:0] wdata_p0;
   logic [31:0] merge_p1;
   logic [31:0] load_data_p1;
   logic        done_q;
   logic        misaligned_q;
   logic        mem_read_q;
   logic        mem_write_q;
   logic        misaligned_req;

   function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      case (off)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      h = off[1] ? word[15:0] : word[31:16];
      case (size)
         2'b00:   if (sgn) r = 32'(b); else r = {24'd0, b};
         2'b01:   if (sgn) r = 32'(h); else r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
      logic [31:0] r;
      r = word;
      case (size)
         2'b00:
            case (off)
               2'd0:    r[31:24] = wdata[7:0];
               2'd1:    r[23:16] = wdata[7:0];
               2'd2:    r[15:8]  = wdata[7:0];
               default: r[7:0]   = wdata[7:0];
            endcase
         2'b01:   if (off[1]) r[15:0] = wdata[15:0]; else r[31:16] = wdata[15:0];
         default: r = wdata;
      endcase
      return r;
   endfunction

`ifdef LSU_ALIGN_CHECK_EN
   assign misaligned_req = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                           (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
   assign misaligned_req = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         load_data_p1 <= 32'd0;
         merge_p1     <= 32'd0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         case (state)
            // p0: capture the request on acceptance
            IDLE: if (bus.req_valid) begin
               addr_p0  <= bus.req_addr;
               size_p0  <= bus.req_size;
               sgn_p0   <= bus.req_signed;
               wdata_p0 <= bus.req_wdata;
               if (misaligned_req) begin
                  done_q       <= 1'b1;
                  misaligned_q <= 1'b1;
               end else if (!bus.req_store) begin
                  state      <= LD;
                  mem_read_q <= 1'b1;
               end else if (bus.req_size[1]) begin
                  merge_p1    <= bus.req_wdata;
                  state       <= ST_WR;
                  mem_write_q <= 1'b1;
               end else begin
                  state      <= ST_RD;
                  mem_read_q <= 1'b1;
               end
            end
            // p1: memory word returned, extract load or merge store lanes
            LD: begin
               load_data_p1 <= extend_load(bus.read_data, size_p0, addr_p0[1:0], sgn_p0);
               done_q       <= 1'b1;
               mem_read_q   <= 1'b0;
               state        <= IDLE;
            end
            ST_RD: begin
               merge_p1    <= merge_store(bus.read_data, wdata_p0, size_p0, addr_p0[1:0]);
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b1;
               state       <= ST_WR;
            end
            // p2: write lands on this edge
            ST_WR: begin
               mem_write_q <= 1'b0;
               done_q      <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready      = (state == IDLE) && !reset;
   assign bus.done           = done_q;
   assign bus.misaligned     = misaligned_q;
   assign bus.load_data      = load_data_p1;
   assign bus.memory_address = addr_p0[17:2];
   assign bus.write_data     = merge_p1;
   assign bus.mem_read       = mem_read_q;
   assign bus.mem_write      = mem_write_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table-driven vectors, scoreboard of done events,
// and hand sequences for back-to-back, alignment and reset-mid-store behaviour.
module tb_load_store_unit;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   load_store_unit_if bus ();
   load_store_unit dut (.clock(clock), .reset(reset), .bus(bus));

   typedef struct {
      logic        store;
      logic [1:0]  size;
      logic        sgn;
      logic [17:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] exp_val;
   } vec_t;

   typedef struct {
      int          cyc;
      logic        mis;
      logic        is_load;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      int          cyc;
      logic        mis;
      logic [31:0] data;
   } obs_t;

   logic [31:0] mem [0:65535];
   logic        pre_en = 1'b0;
   logic [15:0] pre_addr = 16'd0;
   logic [31:0] pre_data = 32'd0;
   int          cyc = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          checks = 0;
   int          errors = 0;
   logic        accepted_with_done;
   exp_t        exp_q[$];
   obs_t        obs_q[$];
   vec_t        vecs[15];

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (bus.mem_write) mem[bus.memory_address] <= bus.write_data;
   end

   always @(negedge clock) if (bus.mem_read) bus.read_data <= mem[bus.memory_address];

   always @(posedge clock) begin
      if (bus.mem_read) rd_cnt <= rd_cnt + 1;
      if (bus.mem_write) wr_cnt <= wr_cnt + 1;
   end

   always @(negedge clock) if (bus.done) obs_q.push_back('{cyc, bus.misaligned, bus.load_data});

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [31:0] d);
      @(negedge clock);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clock);
      #1 pre_en = 1'b0;
   endtask

   task automatic send(input logic store, input logic [1:0] size, input logic sgn,
                       input logic [17:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic scored);
      exp_t e;
      int   waitc;
      logic mis;
      int   lat;
      @(negedge clock);
      bus.req_valid = 1'b1; bus.req_store = store; bus.req_size = size;
      bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
      waitc = 0;
      while (!bus.req_ready && waitc < 50) begin
         @(negedge clock);
         waitc++;
      end
      if (!bus.req_ready) chk("accept_ready", {31'd0, bus.req_ready}, 32'd1);
      accepted_with_done = bus.done;
`ifdef LSU_ALIGN_CHECK_EN
      mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
      mis = 1'b0;
`endif
      lat = mis ? 0 : (!store ? 1 : (size[1] ? 1 : 2));
      e.cyc = cyc + 1 + lat;
      e.mis = mis;
      e.is_load = !store && !mis;
      e.data = exp_data;
      if (scored) exp_q.push_back(e);
      @(posedge clock);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic check_next(input string name);
      obs_t o;
      exp_t e;
      int   n;
      n = 0;
      while (obs_q.size() == 0 && n < 20) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (obs_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s: no done within 20 cycles (expected one)", name);
         return;
      end
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s: unexpected done at cycle %0d (expected none)", name, o.cyc);
         return;
      end
      e = exp_q.pop_front();
      chk({name, "_done_cycle"}, o.cyc, e.cyc);
      chk({name, "_misaligned"}, {31'd0, o.mis}, {31'd0, e.mis});
      if (e.is_load) chk({name, "_load_data"}, o.data, e.data);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int w0;
      vecs[0]  = '{1'b0, 2'b10, 1'b0, 18'h00010, 32'h0,        32'h11223344, 32'h11223344};
      vecs[1]  = '{1'b0, 2'b00, 1'b1, 18'h00013, 32'h0,        32'h112233F4, 32'hFFFFFFF4};
      vecs[2]  = '{1'b0, 2'b00, 1'b0, 18'h00013, 32'h0,        32'h112233F4, 32'h000000F4};
      vecs[3]  = '{1'b0, 2'b01, 1'b1, 18'h00010, 32'h0,        32'h112233F4, 32'h00001122};
      vecs[4]  = '{1'b0, 2'b01, 1'b1, 18'h00012, 32'h0,        32'h1122F344, 32'hFFFFF344};
      vecs[5]  = '{1'b0, 2'b01, 1'b0, 18'h00012, 32'h0,        32'h1122F344, 32'h0000F344};
      vecs[6]  = '{1'b0, 2'b00, 1'b1, 18'h00010, 32'h0,        32'h80223344, 32'hFFFFFF80};
      vecs[7]  = '{1'b0, 2'b00, 1'b0, 18'h00011, 32'h0,        32'h11223344, 32'h00000022};
      vecs[8]  = '{1'b1, 2'b00, 1'b0, 18'h00011, 32'h000000AB, 32'h11223344, 32'h11AB3344};
      vecs[9]  = '{1'b1, 2'b00, 1'b0, 18'h00013, 32'h12345655, 32'h11223344, 32'h11223355};
      vecs[10] = '{1'b1, 2'b01, 1'b0, 18'h00012, 32'hFFFFBEEF, 32'h11223344, 32'h1122BEEF};
      vecs[11] = '{1'b1, 2'b01, 1'b0, 18'h00010, 32'h0000CAFE, 32'h11223344, 32'hCAFE3344};
      vecs[12] = '{1'b1, 2'b10, 1'b0, 18'h00024, 32'hCAFEBABE, 32'h00000000, 32'hCAFEBABE};
      vecs[13] = '{1'b0, 2'b11, 1'b0, 18'h00014, 32'h0,        32'h89ABCDEF, 32'h89ABCDEF};
      vecs[14] = '{1'b1, 2'b00, 1'b0, 18'h00012, 32'h0000005A, 32'hFFFFFFFF, 32'hFFFF5AFF};

      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.req_addr = 18'd0; bus.req_wdata = 32'd0;
      repeat (3) @(posedge clock);
      #1 chk("reset_ready_low", {31'd0, bus.req_ready}, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("reset_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_load_data", bus.load_data, 32'd0);
      chk("reset_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      chk("reset_misaligned", {31'd0, bus.misaligned}, 32'd0);

      for (int i = 0; i < 15; i++) begin
         preload(vecs[i].addr[17:2], vecs[i].init);
         send(vecs[i].store, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_val, 1'b1);
         check_next($sformatf("vec%0d", i));
         if (vecs[i].store) chk($sformatf("vec%0d_mem", i), mem[vecs[i].addr[17:2]], vecs[i].exp_val);
      end

      // Store then load accepted in the store's done cycle
      preload(16'd8, 32'd0);
      send(1'b1, 2'b10, 1'b0, 18'h00020, 32'hDEADBEEF, 32'd0, 1'b1);
      send(1'b0, 2'b10, 1'b0, 18'h00020, 32'd0, 32'hDEADBEEF, 1'b1);
      chk("b2b_accept_in_done", {31'd0, accepted_with_done}, 32'd1);
      check_next("b2b_sw");
      check_next("b2b_lw");

      // Odd halfword load and unaligned word store
      preload(16'd4, 32'h11223344);
      r0 = rd_cnt; w0 = wr_cnt;
      send(1'b0, 2'b01, 1'b0, 18'h00011, 32'd0, 32'h00001122, 1'b1);
      check_next("lh_odd");
`ifdef LSU_ALIGN_CHECK_EN
      chk("lh_odd_no_read", rd_cnt, r0);
      chk("lh_odd_no_write", wr_cnt, w0);
`endif
      send(1'b1, 2'b10, 1'b0, 18'h00012, 32'h0BADF00D, 32'd0, 1'b1);
      check_next("sw_unaligned");
`ifdef LSU_ALIGN_CHECK_EN
      chk("sw_unaligned_mem", mem[4], 32'h11223344);
      chk("sw_unaligned_no_write", wr_cnt, w0);
`else
      chk("sw_unaligned_mem", mem[4], 32'h0BADF00D);
`endif

      // Reset during the read half of a halfword store
      preload(16'd8, 32'h55667788);
      w0 = wr_cnt;
      send(1'b1, 2'b01, 1'b0, 18'h00020, 32'h00001234, 32'd0, 1'b0);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_strd_ready", {31'd0, bus.req_ready}, 32'd1);
      repeat (4) @(negedge clock);
      #1 chk("rst_strd_no_done", obs_q.size(), 32'd0);
      chk("rst_strd_mem", mem[8], 32'h55667788);
      chk("rst_strd_no_write", wr_cnt, w0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
